// File: rtl/data_mem_if.sv
// Request/response bus between the core memory stage (master) and the
// data RAM responder (slave).
//   req_*  : valid/ready request channel (store data right-justified)
//   resp_* : valid/ready response channel (load data zero-extended)
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// On-chip data RAM answering load/store requests from the core, one
// transaction outstanding, fixed access latency.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous reset, active-high (RAM contents are kept)
//   bus  : data_mem_if.slave request/response channels
//
// Store data is committed and load data captured at the accept edge; the
// response is then released LATENCY-1 edges later and held until taken.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request accepted, latency counter running
// RESP  | response presented, waiting for resp_ready
module data_mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic      clk,
    input  logic      rst,
    data_mem_if.slave bus
);

    localparam int         IDX_W    = ADDR_WIDTH - 2;
    localparam int         DEPTH    = 2 ** IDX_W;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         lat_cnt;
    logic [31:0]        pend_rdata;
    logic               pend_err;

    logic [31:0]        mem [DEPTH];

    logic [31:0]        off;
    logic               in_range;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         lane;
    logic               size_err;
    logic               req_err;
    logic [31:0]        rd_word;
    logic [31:0]        rd_shift;
    logic [31:0]        load_data;
    logic [31:0]        resp_data_next;
    logic [31:0]        wr_data;
    logic [3:0]         wr_be;
    logic               accept;
    logic               mem_we;

    // Address decode and error classification
    always_comb begin
        off      = bus.req_addr - BASE_ADDR;
        // unsigned compare of the difference: anything below BASE wraps high
        in_range = (off >> ADDR_WIDTH) == 32'd0;
        word_idx = off[ADDR_WIDTH-1:2];
        lane     = off[1:0];
        size_err = 1'b0;
        case (bus.req_size)
            2'b00:   size_err = 1'b0;
            2'b01:   size_err = lane[0];
            2'b10:   size_err = (lane != 2'b00);
            default: size_err = 1'b1;
        endcase
        req_err = !in_range || size_err;
    end

    // Load path: read the addressed word, shift the selected lane down
    always_comb begin
        rd_word   = mem[word_idx];
        rd_shift  = rd_word >> {lane, 3'b000};
        load_data = 32'd0;
        case (bus.req_size)
            2'b00:   load_data = {24'd0, rd_shift[7:0]};
            2'b01:   load_data = {16'd0, rd_shift[15:0]};
            2'b10:   load_data = rd_word;
            default: load_data = 32'd0;
        endcase
        resp_data_next = (bus.req_we || req_err) ? 32'd0 : load_data;
    end

    // Store path: replicate the right-justified data across lanes, enable
    // only the addressed ones
    always_comb begin
        wr_data = 32'd0;
        wr_be   = 4'b0000;
        case (bus.req_size)
            2'b00: begin
                wr_data = {4{bus.req_wdata[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            2'b01: begin
                wr_data = {2{bus.req_wdata[15:0]}};
                wr_be   = 4'b0011 << lane;
            end
            2'b10: begin
                wr_data = bus.req_wdata;
                wr_be   = 4'b1111;
            end
            default: begin
                wr_data = 32'd0;
                wr_be   = 4'b0000;
            end
        endcase
    end

    assign accept = (state == IDLE) && bus.req_ready && bus.req_valid && !rst;
    assign mem_we = accept && bus.req_we && !req_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lat_cnt        <= 4'd0;
            pend_rdata     <= 32'd0;
            pend_err       <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= resp_data_next;
                            bus.resp_err   <= req_err;
                        end else begin
                            state      <= WAIT;
                            lat_cnt    <= LAT_LOAD;
                            pend_rdata <= resp_data_next;
                            pend_err   <= req_err;
                        end
                    end
                end
                WAIT: begin
                    // counter at 1 means this edge is the one that takes it to 0
                    if (lat_cnt == 4'd1) begin
                        state          <= RESP;
                        lat_cnt        <= 4'd0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= pend_rdata;
                        bus.resp_err   <= pend_err;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b0;
                        bus.resp_rdata <= 32'd0;
                        bus.resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances with LATENCY 2, 1
// and 4 share clock and reset; index 0/1/2 selects the instance.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  rv, rwe, rr;
    logic [1:0]  rsz    [3];
    logic [31:0] raddr  [3];
    logic [31:0] rwd    [3];
    logic [2:0]  ordy, ovld, oerr;
    logic [31:0] ordata [3];

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        data_mem_responder #(
            .ADDR_WIDTH (12),
            .LATENCY    (LAT),
            .BASE_ADDR  (32'h8000_0000)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
        assign bus[g].req_valid  = rv[g];
        assign bus[g].req_we     = rwe[g];
        assign bus[g].req_size   = rsz[g];
        assign bus[g].req_addr   = raddr[g];
        assign bus[g].req_wdata  = rwd[g];
        assign bus[g].resp_ready = rr[g];
        assign ordy[g]   = bus[g].req_ready;
        assign ovld[g]   = bus[g].resp_valid;
        assign oerr[g]   = bus[g].resp_err;
        assign ordata[g] = bus[g].resp_rdata;
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One full transaction with resp_ready high; lat counts edges from the
    // accept edge until resp_valid is seen (1 = visible right after accept).
    task automatic txn(input int s, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n;
        rwe[s] = we; rsz[s] = sz; raddr[s] = addr; rwd[s] = wd;
        rr[s] = 1'b1; rv[s] = 1'b1;
        n = 0;
        while (!ordy[s] && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rv[s] = 1'b0;
        lat = 1;
        while (!ovld[s] && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = ordata[s];
        err   = oerr[s];
        check("txn_bound", {31'd0, (n < 40 && lat < 40)}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic rd(input int s, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] exp, input logic exp_err, input string tag);
        logic [31:0] d; logic e; int lat;
        txn(s, 1'b0, sz, addr, 32'd0, d, e, lat);
        check({tag, "_data"}, d, exp);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        check({tag, "_lat"}, lat, lat_of(s));
    endtask

    task automatic wr(input int s, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic exp_err, input string tag);
        logic [31:0] d; logic e; int lat;
        txn(s, 1'b1, sz, addr, wd, d, e, lat);
        check({tag, "_data"}, d, 32'd0);
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        check({tag, "_lat"}, lat, lat_of(s));
    endtask

    // Hold req_valid high with resp_ready high and measure accept spacing
    task automatic b2b(input int s, input int exp_gap, input string tag);
        int first, second;
        logic acc;
        first = -1; second = -1;
        rwe[s] = 1'b0; rsz[s] = 2'b10; raddr[s] = 32'h8000_0010;
        rr[s] = 1'b1; rv[s] = 1'b1;
        for (int i = 0; i < 40 && second < 0; i++) begin
            acc = ordy[s];
            @(posedge clk); #1;
            if (acc) begin
                if (first < 0) first = i;
                else second = i;
            end
        end
        rv[s] = 1'b0;
        check(tag, second - first, exp_gap);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rv = '0; rwe = '0; rr = '0;
        for (int i = 0; i < 3; i++) begin
            rsz[i] = 2'b00; raddr[i] = 32'd0; rwd[i] = 32'd0;
        end

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ordy[0]}, 32'd0);
        check("rst_valid", {29'd0, ovld}, 32'd0);
        check("rst_rdata", ordata[0], 32'd0);
        check("rst_err",   {29'd0, oerr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {29'd0, ordy}, 32'h7);

        // basic store/load
        wr(0, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, "sw_basic");
        rd(0, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, "lw_basic");

        // sub-word
        wr(0, 2'b10, 32'h8000_0020, 32'h1122_3344, 1'b0, "sw_sub");
        wr(0, 2'b00, 32'h8000_0023, 32'hFFFF_FFAA, 1'b0, "sb_sub");
        wr(0, 2'b01, 32'h8000_0020, 32'hFFFF_5566, 1'b0, "sh_sub");
        rd(0, 2'b10, 32'h8000_0020, 32'hAA22_5566, 1'b0, "lw_sub");
        rd(0, 2'b00, 32'h8000_0023, 32'h0000_00AA, 1'b0, "lb_3");
        rd(0, 2'b00, 32'h8000_0021, 32'h0000_0055, 1'b0, "lb_1");
        rd(0, 2'b01, 32'h8000_0022, 32'h0000_AA22, 1'b0, "lh_2");

        // errors
        wr(0, 2'b10, 32'h8000_0000, 32'hCAFE_F00D, 1'b0, "sw_word0");
        rd(0, 2'b01, 32'h8000_0021, 32'd0, 1'b1, "lh_misalign");
        wr(0, 2'b10, 32'h8000_0022, 32'hFFFF_FFFF, 1'b1, "sw_misalign");
        rd(0, 2'b10, 32'h8000_0020, 32'hAA22_5566, 1'b0, "lw_after_sw_mis");
        rd(0, 2'b10, 32'h8000_1000, 32'd0, 1'b1, "lw_oor");
        rd(0, 2'b10, 32'h7FFF_FFFC, 32'd0, 1'b1, "lw_below");
        wr(0, 2'b00, 32'h8000_1000, 32'h0000_0077, 1'b1, "sb_oor");
        rd(0, 2'b10, 32'h8000_0000, 32'hCAFE_F00D, 1'b0, "lw_after_sb_oor");
        wr(0, 2'b11, 32'h8000_0020, 32'd0, 1'b1, "st_size3");
        rd(0, 2'b11, 32'h8000_0020, 32'd0, 1'b1, "ld_size3");
        rd(0, 2'b10, 32'h8000_0020, 32'hAA22_5566, 1'b0, "lw_after_size3");

        // top word of the RAM
        wr(0, 2'b10, 32'h8000_0FFC, 32'h0BAD_C0DE, 1'b0, "sw_top");
        rd(0, 2'b01, 32'h8000_0FFE, 32'h0000_0BAD, 1'b0, "lh_top");

        // backpressure
        wr(0, 2'b10, 32'h8000_0030, 32'd0, 1'b0, "sw_bp_init");
        rwe[0] = 1'b0; rsz[0] = 2'b10; raddr[0] = 32'h8000_0010;
        rr[0] = 1'b0; rv[0] = 1'b1;
        n = 0;
        while (!ordy[0] && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rwe[0] = 1'b1; raddr[0] = 32'h8000_0030; rwd[0] = 32'h9999_9999;
        n = 0;
        while (!ovld[0] && n < 40) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, ovld[0]}, 32'd1);
            check("bp_rdata", ordata[0], 32'hDEAD_BEEF);
            check("bp_ready", {31'd0, ordy[0]}, 32'd0);
            @(posedge clk); #1;
        end
        rr[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, ovld[0]}, 32'd0);
        check("bp_release_ready", {31'd0, ordy[0]}, 32'd1);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        check("bp_new_accepted", {31'd0, ordy[0]}, 32'd0);
        n = 0;
        while (!ovld[0] && n < 40) begin @(posedge clk); #1; n++; end
        check("bp_new_err", {31'd0, oerr[0]}, 32'd0);
        @(posedge clk); #1;
        rd(0, 2'b10, 32'h8000_0030, 32'h9999_9999, 1'b0, "lw_bp_store");

        // latency sweep
        wr(1, 2'b10, 32'h8000_0100, 32'h0102_0304, 1'b0, "sw_l1");
        rd(1, 2'b10, 32'h8000_0100, 32'h0102_0304, 1'b0, "lw_l1");
        wr(2, 2'b10, 32'h8000_0104, 32'hA5A5_5A5A, 1'b0, "sw_l4");
        rd(2, 2'b00, 32'h8000_0105, 32'h0000_005A, 1'b0, "lb_l4");
        b2b(0, 3, "b2b_gap_l2");
        b2b(1, 2, "b2b_gap_l1");
        b2b(2, 5, "b2b_gap_l4");

        // reset in WAIT
        rwe[0] = 1'b1; rsz[0] = 2'b10; raddr[0] = 32'h8000_0040;
        rwd[0] = 32'h1234_5678; rr[0] = 1'b1; rv[0] = 1'b1;
        n = 0;
        while (!ordy[0] && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rv[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", {31'd0, ovld[0]}, 32'd0);
        check("rst_mid_ready", {31'd0, ordy[0]}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_mid_no_resp", {31'd0, ovld[0]}, 32'd0);
        end
        check("rst_mid_ready_after", {31'd0, ordy[0]}, 32'd1);
        rd(0, 2'b10, 32'h8000_0040, 32'h1234_5678, 1'b0, "lw_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: on-chip data RAM that serves load/store requests from the core's memory stage.
- Uses a valid/ready request channel and a valid/ready response channel, with a configurable access latency.
- Handles one outstanding transaction.
- Returns load data right-justified and zero-extended; sign extension stays with the requester.

Parameters:
ADDR_WIDTH, 12, byte-address bits inside the RAM; the RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
LATENCY, 2, clock edges from request acceptance to resp_valid; legal range 1..15.
BASE_ADDR, 32'h8000_0000, byte address of RAM word 0; must be aligned to 2^ADDR_WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified (byte uses [7:0], half uses [15:0]).
resp_valid  output  1  response present.
resp_ready  input  1  requester accepts the response.
resp_rdata  output  32  load data, zero-extended; 0 for stores and errors.
resp_err  output  1  request was misaligned, out of range or illegal size.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - req_ready=0 during reset, 1 in the first cycle after reset.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge; a latency counter is loaded with LATENCY-1. Next state is RESP if LATENCY==1, else WAIT.
  - WAIT: req_ready=0. The counter decrements each edge; on reaching 0 the next state is RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err are held stable. When resp_ready=1, next state is IDLE. The response and a new request are never accepted on the same edge.
- Latency: request accepted at edge N gives resp_valid high from just after edge N+LATENCY-1, i.e. first visible in cycle N+LATENCY counting the accept cycle as N.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - In range iff off < 2^ADDR_WIDTH (unsigned compare of the 32-bit difference).
  - Word index = off[ADDR_WIDTH-1:2]; lane = off[1:0].
- Error conditions (resp_err=1, rdata=0, RAM untouched):
  - address out of range;
  - size==11;
  - half with lane[0]=1;
  - word with lane!=0.
- Store commit: at the accept edge.
  - Byte: wdata[7:0] is written to byte lane `lane`.
  - Half: wdata[15:0] is written to lanes lane+1:lane.
  - Word: all 4 lanes are written.
  - Other lanes of the word are preserved.
- Load capture: at the accept edge, so a load always sees all previously accepted stores.
  - Byte returns {24'b0, selected byte}.
  - Half returns {16'b0, selected half}.
  - Word returns the full word.
- Store response: resp_rdata=0, resp_err per the error checks.
- Byte order is little-endian: lane 0 = bits [7:0].
- Reset mid-transaction (WAIT or RESP): the pending response is discarded and the FSM returns to IDLE. A store accepted before reset stays committed.
- Request inputs are ignored outside IDLE. They need not be held stable after acceptance.
- resp_ready is ignored outside RESP.

Test Plan:
- Basic store/load, LATENCY=2:
  - Stimulus: sw 0xDEADBEEF at 0x8000_0010, then lw at 0x8000_0010.
  - Required: store resp_valid in cycle 2 after accept with err=0, rdata=0; load rdata=0xDEADBEEF.
- Sub-word stores and loads:
  - Stimulus: sw 0x11223344 at 0x8000_0020; sb 0xAA at 0x8000_0023; sh 0x5566 at 0x8000_0020.
  - Required: lw returns 0xAA225566; lb at 0x8000_0023 returns 0x000000AA; lh at 0x8000_0022 returns 0x0000AA22.
- Error cases, each giving err=1, rdata=0, RAM unchanged (checked by a follow-up lw):
  - lh at 0x8000_0021;
  - sw at 0x8000_0022;
  - lw at 0x8000_1000 (ADDR_WIDTH=12);
  - size=11.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles in RESP while req_valid is driven with a new request.
  - Required: resp_valid and resp_rdata stay stable, req_ready=0, the new request is not accepted; after resp_ready=1, IDLE, then it is accepted.
- Latency sweep:
  - Stimulus: LATENCY=1 and LATENCY=4, lw each.
  - Required: resp_valid first high exactly 1 and 4 cycles after the accept edge; back-to-back requests give one accept per LATENCY+1 cycles with resp_ready tied high.
- Reset mid-operation:
  - Stimulus: assert rst one cycle into WAIT of an sw 0x12345678 at 0x8000_0040.
  - Required: no resp_valid, req_ready=1 after reset release; a subsequent lw returns 0x12345678.
